ws2812_tx_sequencer: RTL

WS2812_TX_SEQUENCER -- requirements
Module: ws2812_tx_sequencer

---
 rtl/ws2812_tx_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ws2812_tx_sequencer.sv
// WS2812 one-wire encoder: accepts 24-bit GRB pixels over a valid/ready port,
// sends each bit MSB first as a pulse-width code, and closes a frame with a low latch gap.
module ws2812_tx_sequencer #(
  parameter int NUM_PIXELS   = 64,
  parameter int BIT_CYCLES   = 15,
  parameter int T0H_CYCLES   = 4,
  parameter int T1H_CYCLES   = 8,
  parameter int LATCH_CYCLES = 3600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_valid,
  input  logic [23:0] pixel_data,
  output logic        pixel_ready,
  input  logic        frame_abort,
  output logic        data_out,
  output logic [5:0]  pixel_index,
  output logic        busy,
  output logic        frame_done
);

  // Pixel handshake: a pixel moves on a rising edge where pixel_valid and
  // pixel_ready are both high. pixel_ready is a registered WAIT-state flag, so
  // it never depends combinationally on pixel_valid; upstream holds pixel_data
  // stable while pixel_valid=1 and pixel_ready=0.

  localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(BIT_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_ONE    = CYC_W'(1);
  localparam logic [CYC_W-1:0] T0H_LIMIT  = CYC_W'(T0H_CYCLES);
  localparam logic [CYC_W-1:0] T1H_LIMIT  = CYC_W'(T1H_CYCLES);
  localparam logic [LAT_W-1:0] LATCH_LAST = LAT_W'(LATCH_CYCLES - 1);
  localparam logic [LAT_W-1:0] LAT_ONE    = LAT_W'(1);
  localparam logic [5:0]       LAST_INDEX = 6'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_SEND  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [23:0]      shreg, shreg_n;
  logic [4:0]       bit_cnt, bit_cnt_n;
  logic [CYC_W-1:0] cyc_cnt, cyc_cnt_n;
  logic [LAT_W-1:0] latch_cnt, latch_cnt_n;
  logic [5:0]       index_n;
  logic [CYC_W-1:0] high_limit;
  logic             ready_n;
  logic             data_n;
  logic             busy_n;
  logic             done_n;

  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    bit_cnt_n   = bit_cnt;
    cyc_cnt_n   = cyc_cnt;
    latch_cnt_n = latch_cnt;
    index_n     = pixel_index;
    done_n      = 1'b0;

    case (state)
      ST_WAIT: begin
        // An abort outranks a simultaneous transfer and only counts mid-frame.
        if (frame_abort && (pixel_index != 6'd0)) begin
          state_n     = ST_LATCH;
          latch_cnt_n = '0;
        end else if (pixel_valid && pixel_ready) begin
          state_n   = ST_SEND;
          shreg_n   = pixel_data;
          bit_cnt_n = 5'd23;
          cyc_cnt_n = '0;
        end
      end

      ST_SEND: begin
        if (cyc_cnt == CYC_LAST) begin
          cyc_cnt_n = '0;
          shreg_n   = {shreg[22:0], 1'b0};
          if (bit_cnt == 5'd0) begin
            if (pixel_index == LAST_INDEX) begin
              state_n     = ST_LATCH;
              latch_cnt_n = '0;
            end else begin
              state_n = ST_WAIT;
              index_n = pixel_index + 6'd1;
            end
          end else begin
            bit_cnt_n = bit_cnt - 5'd1;
          end
        end else begin
          cyc_cnt_n = cyc_cnt + CYC_ONE;
        end
      end

      ST_LATCH: begin
        if (latch_cnt == LATCH_LAST) begin
          state_n     = ST_WAIT;
          latch_cnt_n = '0;
          index_n     = 6'd0;
          done_n      = 1'b1;
        end else begin
          latch_cnt_n = latch_cnt + LAT_ONE;
        end
      end

      default: begin
        state_n = ST_WAIT;
      end
    endcase

    // Outputs are computed from the next-state values and registered, so the
    // line level seen in a cycle always matches the state held in that cycle.
    high_limit = shreg_n[23] ? T1H_LIMIT : T0H_LIMIT;
    ready_n    = (state_n == ST_WAIT);
    busy_n     = (state_n != ST_WAIT);
    data_n     = (state_n == ST_SEND) && (cyc_cnt_n < high_limit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_WAIT;
      shreg       <= '0;
      bit_cnt     <= '0;
      cyc_cnt     <= '0;
      latch_cnt   <= '0;
      pixel_index <= 6'd0;
      pixel_ready <= 1'b0;
      data_out    <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      bit_cnt     <= bit_cnt_n;
      cyc_cnt     <= cyc_cnt_n;
      latch_cnt   <= latch_cnt_n;
      pixel_index <= index_n;
      pixel_ready <= ready_n;
      data_out    <= data_n;
      busy        <= busy_n;
      frame_done  <= done_n;
    end
  end

endmodule
